apb_multi_initiator: RTL and testbench

//  Parametrised APB4 initiator: converts a held-request/ack-pulse bus (VProc-style addr/we/rd/be)

---
 rtl/apb_multi_initiator.sv | 177 +++++++++++++++++
 tb/tb_apb_multi_initiator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_initiator.sv
// apb_multi_initiator
//   Converts a held-request / ack-pulse bus (addr, wdata, be, we, rd) into APB4 transfers.
//   It decodes the completer select from an address field and muxes the selected completer's
//   read data. A transfer that waits too long for PREADY ends with an error, and a sticky error
//   flag records any error completion.
//
// Ports
//   pclk, presetn        clock, synchronous active-low reset
//   req_addr/req_wdata   request address / write data, held by the requester until req_ack
//   req_be               write byte enables
//   req_we/req_rd        request level (exactly one high = valid transfer, both = error)
//   req_ack              one-cycle completion pulse
//   req_rdata/req_err    read data / error status, valid with req_ack, held otherwise
//   err_sticky/err_clr   sticky error flag and its clear (a set in the same cycle wins)
//   psel..pprot          APB4 initiator outputs (all registered, pprot constant)
//   prdata/pready/pslverr  per-completer responses, completer i at slice i

module apb_multi_initiator #(
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SLV_LSB   = 12,
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [2:0]  PROT      = 3'b010
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [ADDRWIDTH-1:0]      req_addr,
    input  logic [DATAWIDTH-1:0]      req_wdata,
    input  logic [DATAWIDTH/8-1:0]    req_be,
    input  logic                      req_we,
    input  logic                      req_rd,
    output logic                      req_ack,
    output logic [DATAWIDTH-1:0]      req_rdata,
    output logic                      req_err,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [NSLV-1:0]           psel,
    output logic [ADDRWIDTH-1:0]      paddr,
    output logic [DATAWIDTH-1:0]      pwdata,
    output logic                      pwrite,
    output logic                      penable,
    output logic [DATAWIDTH/8-1:0]    pstrb,
    output logic [2:0]                pprot,
    input  logic [NSLV*DATAWIDTH-1:0] prdata,
    input  logic [NSLV-1:0]           pready,
    input  logic [NSLV-1:0]           pslverr
);

    localparam int unsigned IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [CNTW-1:0]   cnt_q;

    logic [IDXW-1:0]      req_idx;
    logic                 idx_hit;
    logic [NSLV-1:0]      idx_dec;
    logic                 sel_ready;
    logic                 sel_err;
    logic [DATAWIDTH-1:0] sel_rdata;
    logic                 timeout_hit;

    assign req_idx = req_addr[SLV_LSB +: IDXW];
    assign idx_hit = 32'(req_idx) < NSLV;

    always_comb begin
        idx_dec = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            idx_dec[i] = (req_idx == IDXW'(i));
        end
    end

    // Only the captured completer is ever looked at.
    assign sel_ready = pready[idx_q];
    assign sel_err   = pslverr[idx_q];
    assign sel_rdata = prdata[idx_q*DATAWIDTH +: DATAWIDTH];

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNTW'(TIMEOUT - 1));

    assign pprot = PROT;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            psel       <= '0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            req_ack    <= 1'b0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            req_ack <= 1'b0;
            // Any set further down overrides this clear.
            if (err_clr) begin
                err_sticky <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (req_rd ^ req_we) begin
                        paddr  <= req_addr;
                        pwdata <= req_wdata;
                        pwrite <= req_we;
                        idx_q  <= req_idx;
                        cnt_q  <= '0;
                        if (idx_hit) begin
                            psel    <= idx_dec;
                            pstrb   <= req_we ? req_be : '0;
                            state_q <= StSetup;
                        end else begin
                            // Decode miss: complete with error, no bus activity.
                            req_ack    <= 1'b1;
                            req_err    <= 1'b1;
                            req_rdata  <= '0;
                            err_sticky <= 1'b1;
                            state_q    <= StDone;
                        end
                    end else if (req_rd && req_we) begin
                        req_ack    <= 1'b1;
                        req_err    <= 1'b1;
                        req_rdata  <= '0;
                        err_sticky <= 1'b1;
                        state_q    <= StDone;
                    end
                end

                StSetup: begin
                    penable <= 1'b1;
                    state_q <= StAccess;
                end

                StAccess: begin
                    if (sel_ready) begin
                        psel      <= '0;
                        penable   <= 1'b0;
                        req_ack   <= 1'b1;
                        req_err   <= sel_err;
                        req_rdata <= pwrite ? '0 : sel_rdata;
                        if (sel_err) begin
                            err_sticky <= 1'b1;
                        end
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        psel       <= '0;
                        penable    <= 1'b0;
                        req_ack    <= 1'b1;
                        req_err    <= 1'b1;
                        req_rdata  <= '0;
                        err_sticky <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    // Guarantees one IDLE cycle so a request still held at ack is dropped first.
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_initiator.sv
module tb_apb_multi_initiator;

    localparam int TO_A = 8;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;
    logic presetn;

    // Instance A: 32-bit, 4 completers, timeout 8
    logic [31:0]  a_req_addr, a_req_wdata, a_req_rdata, a_paddr, a_pwdata;
    logic [3:0]   a_req_be, a_psel, a_pstrb, a_pready, a_pslverr;
    logic         a_req_we, a_req_rd, a_req_ack, a_req_err, a_err_sticky, a_err_clr;
    logic         a_pwrite, a_penable;
    logic [2:0]   a_pprot;
    logic [127:0] a_prdata;

    // Instance B: 64-bit, 3 completers, timeout disabled
    logic [63:0]  b_req_addr, b_req_wdata, b_req_rdata, b_paddr, b_pwdata;
    logic [7:0]   b_req_be, b_pstrb;
    logic [2:0]   b_psel, b_pready, b_pslverr, b_pprot;
    logic         b_req_we, b_req_rd, b_req_ack, b_req_err, b_err_sticky, b_err_clr;
    logic         b_pwrite, b_penable;
    logic [191:0] b_prdata;

    apb_multi_initiator #(
        .ADDRWIDTH(32), .DATAWIDTH(32), .NSLV(4), .SLV_LSB(12), .TIMEOUT(TO_A), .PROT(3'b010)
    ) u_dut_a (
        .pclk(pclk), .presetn(presetn),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .req_we(a_req_we), .req_rd(a_req_rd), .req_ack(a_req_ack),
        .req_rdata(a_req_rdata), .req_err(a_req_err),
        .err_sticky(a_err_sticky), .err_clr(a_err_clr),
        .psel(a_psel), .paddr(a_paddr), .pwdata(a_pwdata), .pwrite(a_pwrite),
        .penable(a_penable), .pstrb(a_pstrb), .pprot(a_pprot),
        .prdata(a_prdata), .pready(a_pready), .pslverr(a_pslverr)
    );

    apb_multi_initiator #(
        .ADDRWIDTH(64), .DATAWIDTH(64), .NSLV(3), .SLV_LSB(12), .TIMEOUT(0), .PROT(3'b010)
    ) u_dut_b (
        .pclk(pclk), .presetn(presetn),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .req_we(b_req_we), .req_rd(b_req_rd), .req_ack(b_req_ack),
        .req_rdata(b_req_rdata), .req_err(b_req_err),
        .err_sticky(b_err_sticky), .err_clr(b_err_clr),
        .psel(b_psel), .paddr(b_paddr), .pwdata(b_pwdata), .pwrite(b_pwrite),
        .penable(b_penable), .pstrb(b_pstrb), .pprot(b_pprot),
        .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycle (edges after the request goes up) at which req_ack is seen,
    // plus the completion status, straight from the transfer rules.
    function automatic void model_a(input bit we, input bit rd, input int w, input bit slverr,
                                    input logic [31:0] data, output int ack_k, output bit err,
                                    output logic [31:0] rdata, output bit bus);
        bus = !(we && rd);
        if (!bus) begin
            ack_k = 1; err = 1'b1; rdata = '0;
        end else if (w + 1 > TO_A) begin
            ack_k = 2 + TO_A; err = 1'b1; rdata = '0;
        end else begin
            ack_k = 3 + w; err = slverr; rdata = we ? 32'h0 : data;
        end
    endfunction

    // Completer behaviour: target answers after w wait states; others drive noise.
    task automatic drive_a(input int idx, input int k, input int w, input bit slverr,
                           input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            if (i == idx) begin
                a_pready[i]            = (k >= 2 + w);
                a_pslverr[i]           = slverr;
                a_prdata[i*32 +: 32]   = data;
            end else begin
                a_pready[i]            = 1'($urandom_range(0, 1));
                a_pslverr[i]           = 1'($urandom_range(0, 1));
                a_prdata[i*32 +: 32]   = $urandom;
            end
        end
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_psel"}, 64'(a_psel), 64'h0);
        check({tag, "_penable"}, 64'(a_penable), 64'h0);
        check({tag, "_pwrite"}, 64'(a_pwrite), 64'h0);
        check({tag, "_paddr"}, 64'(a_paddr), 64'h0);
        check({tag, "_pwdata"}, 64'(a_pwdata), 64'h0);
        check({tag, "_pstrb"}, 64'(a_pstrb), 64'h0);
        check({tag, "_ack"}, 64'(a_req_ack), 64'h0);
        check({tag, "_rdata"}, 64'(a_req_rdata), 64'h0);
        check({tag, "_err"}, 64'(a_req_err), 64'h0);
        check({tag, "_sticky"}, 64'(a_err_sticky), 64'h0);
    endtask

    // Called #1 after an edge with instance A idle.
    task automatic xfer_a(input string tag, input logic [31:0] addr, input bit we, input bit rd,
                          input logic [31:0] wdata, input logic [3:0] be, input int w,
                          input bit slverr, input logic [31:0] data);
        int          idx, exp_k, got_k;
        bit          exp_err, bus, got_err;
        logic [31:0] exp_rdata, got_rdata;
        idx = int'(addr[13:12]);
        model_a(we, rd, w, slverr, data, exp_k, exp_err, exp_rdata, bus);
        got_k = -1; got_err = 1'b0; got_rdata = '0;
        a_req_addr = addr; a_req_wdata = wdata; a_req_be = be; a_req_we = we; a_req_rd = rd;
        drive_a(idx, 0, w, slverr, data);
        for (int k = 1; k <= 40; k++) begin
            @(posedge pclk); #1;
            if (k == 1 && bus) begin
                check({tag, "_setup_psel"}, 64'(a_psel), 64'(4'b0001 << idx));
                check({tag, "_setup_penable"}, 64'(a_penable), 64'h0);
                check({tag, "_setup_paddr"}, 64'(a_paddr), 64'(addr));
                check({tag, "_setup_pwrite"}, 64'(a_pwrite), 64'(we));
                check({tag, "_setup_pstrb"}, 64'(a_pstrb), we ? 64'(be) : 64'h0);
                check({tag, "_pprot"}, 64'(a_pprot), 64'h2);
                // Changes mid-transfer must not reach the bus.
                a_req_addr = $urandom; a_req_wdata = $urandom; a_req_be = 4'($urandom);
            end
            if (k == 1 && !bus) begin
                check({tag, "_no_psel"}, 64'(a_psel), 64'h0);
            end
            if (k == 2 && bus) begin
                check({tag, "_access_penable"}, 64'(a_penable), 64'h1);
                check({tag, "_access_psel"}, 64'(a_psel), 64'(4'b0001 << idx));
                check({tag, "_access_paddr"}, 64'(a_paddr), 64'(addr));
                check({tag, "_access_pwdata"}, 64'(a_pwdata), 64'(wdata));
            end
            if (got_k < 0 && a_req_ack === 1'b1) begin
                got_k = k; got_err = a_req_err; got_rdata = a_req_rdata;
                a_req_we = 1'b0; a_req_rd = 1'b0;
            end else if (got_k >= 0) begin
                check({tag, "_ack_one_cycle"}, 64'(a_req_ack), 64'h0);
                check({tag, "_rdata_held"}, 64'(a_req_rdata), 64'(got_rdata));
                break;
            end
            drive_a(idx, k, w, slverr, data);
        end
        check({tag, "_ack_cycle"}, 64'(got_k), 64'(exp_k));
        if (got_k >= 0) begin
            check({tag, "_err"}, 64'(got_err), 64'(exp_err));
            if (bus) check({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
            if (exp_err) check({tag, "_sticky"}, 64'(a_err_sticky), 64'h1);
        end
        a_req_we = 1'b0; a_req_rd = 1'b0;
    endtask

    task automatic xfer_b(input string tag, input logic [63:0] addr, input bit we, input bit rd,
                          input int exp_k, input bit exp_err, input bit bus,
                          input logic [63:0] exp_rdata);
        int          got_k;
        bit          any_sel, got_err;
        logic [63:0] got_rdata;
        got_k = -1; any_sel = 1'b0; got_err = 1'b0; got_rdata = '0;
        b_req_addr = addr; b_req_wdata = {$urandom, $urandom}; b_req_be = 8'hFF;
        b_req_we = we; b_req_rd = rd;
        for (int k = 1; k <= 20; k++) begin
            @(posedge pclk); #1;
            if (b_psel !== 3'b000) any_sel = 1'b1;
            if (k == 1 && bus) begin
                check({tag, "_setup_psel"}, 64'(b_psel), 64'(3'b001 << addr[13:12]));
                check({tag, "_setup_pstrb"}, 64'(b_pstrb), we ? 64'hFF : 64'h0);
                check({tag, "_setup_paddr"}, b_paddr, addr);
            end
            if (got_k < 0 && b_req_ack === 1'b1) begin
                got_k = k; got_err = b_req_err; got_rdata = b_req_rdata;
                b_req_we = 1'b0; b_req_rd = 1'b0;
            end else if (got_k >= 0) begin
                check({tag, "_ack_one_cycle"}, 64'(b_req_ack), 64'h0);
                break;
            end
        end
        check({tag, "_ack_cycle"}, 64'(got_k), 64'(exp_k));
        check({tag, "_err"}, 64'(got_err), 64'(exp_err));
        if (bus) check({tag, "_rdata"}, got_rdata, exp_rdata);
        else check({tag, "_psel_never"}, 64'(any_sel), 64'h0);
        b_req_we = 1'b0; b_req_rd = 1'b0;
    endtask

    initial begin
        int          idx, r, w;
        bit          we, rd;
        logic [31:0] addr;

        presetn = 1'b0;
        a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_req_we = 0; a_req_rd = 0;
        a_err_clr = 1'b0; a_prdata = '0; a_pready = '0; a_pslverr = '0;
        b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_req_we = 0; b_req_rd = 0;
        b_err_clr = 1'b0; b_prdata = '0; b_pready = '0; b_pslverr = '0;
        repeat (3) @(posedge pclk);
        #1;
        check_a_reset("reset");
        check("reset_b_psel", 64'(b_psel), 64'h0);
        check("reset_b_ack", 64'(b_req_ack), 64'h0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Directed: write, read with waits, timeout and its edges, both-high, slave error.
        xfer_a("t1_wr", 32'h0000_1004, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, $urandom);
        xfer_a("t2_rd", 32'h0000_3008, 1'b0, 1'b1, $urandom, 4'h3, 2, 1'b0, 32'h1234_5678);
        xfer_a("t3_to", 32'h0000_2000, 1'b0, 1'b1, $urandom, 4'hF, 20, 1'b0, $urandom);
        a_err_clr = 1'b1;
        @(posedge pclk); #1;
        a_err_clr = 1'b0;
        check("t3_sticky_clr", 64'(a_err_sticky), 64'h0);
        xfer_a("t3_w7", 32'h0000_1010, 1'b0, 1'b1, $urandom, 4'hF, 7, 1'b0, 32'hCAFE_F00D);
        xfer_a("t3_w8", 32'h0000_1010, 1'b0, 1'b1, $urandom, 4'hF, 8, 1'b0, 32'hCAFE_F00D);
        xfer_a("t4_both", 32'h0000_2004, 1'b1, 1'b1, $urandom, 4'hF, 0, 1'b0, $urandom);
        xfer_a("t5_slverr", 32'h0000_0040, 1'b1, 1'b0, 32'h5555_AAAA, 4'h5, 1, 1'b1, $urandom);

        // Reset during ACCESS aborts with no ack.
        a_req_addr = 32'h0000_1000; a_req_rd = 1'b1; a_req_we = 1'b0;
        drive_a(1, 0, 30, 1'b0, 32'h0BAD_0BAD);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("t5_in_access", 64'(a_penable), 64'h1);
        presetn = 1'b0;
        @(posedge pclk); #1;
        check_a_reset("t5_midrst");
        presetn = 1'b1; a_req_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            check("t5_no_ack", 64'(a_req_ack), 64'h0);
        end

        // Randomized transfers against the model.
        for (int n = 0; n < 24; n++) begin
            idx  = $urandom_range(0, 3);
            addr = $urandom;
            addr[13:12] = 2'(idx);
            we = 1'($urandom_range(0, 1));
            rd = !we;
            if ($urandom_range(0, 7) == 0) begin
                we = 1'b1; rd = 1'b1;
            end
            r = $urandom_range(0, 9);
            w = (r < 8) ? (r % 4) : ((r == 8) ? 7 : 12);
            xfer_a($sformatf("rnd%0d", n), addr, we, rd, $urandom, 4'($urandom), w,
                   1'($urandom_range(0, 1)), $urandom);
        end

        // Instance B: decode miss, both-high, and a full 64-bit read.
        b_pready  = 3'b111;
        b_pslverr = 3'b000;
        b_prdata  = {64'h0123_4567_89AB_CDEF, {$urandom, $urandom}, {$urandom, $urandom}};
        xfer_b("t4_miss", 64'h0000_0000_0000_3000, 1'b0, 1'b1, 1, 1'b1, 1'b0, 64'h0);
        xfer_b("t4_b_both", 64'h0000_0000_0000_0000, 1'b1, 1'b1, 1, 1'b1, 1'b0, 64'h0);
        xfer_b("t6_rd64", 64'hFFFF_0000_0000_2010, 1'b0, 1'b1, 3, 1'b0, 1'b1,
               64'h0123_4567_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
